// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-period math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic logic [31:0] calc_div(input logic [31:0] clk_freq,
                                           input logic [31:0] baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO of depth 2^EA; extra pointer MSB distinguishes full from empty.
module uart_rx_fifo #(
  parameter int EA   = 2,
  parameter bit FWFT = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_empty,
  output logic       o_full,
  output logic [7:0] o_data
);
  localparam int DEPTH = 1 << EA;

  logic [7:0]  r_mem [DEPTH];
  logic [EA:0] r_wptr;
  logic [EA:0] r_rptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[EA] != r_rptr[EA]) && (r_wptr[EA-1:0] == r_rptr[EA-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[EA-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_data = o_empty ? 8'h00 : r_mem[r_rptr[EA-1:0]];
    end else begin : g_std
      logic [7:0] r_dout;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_dout <= 8'h00;
        else if (w_pop_ok) r_dout <= r_mem[r_rptr[EA-1:0]];
      end
      assign o_data = r_dout;
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver: mid-bit sampling, optional parity, output register or FWFT FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter string       PARITY    = "NONE",
  parameter int          FIFO_EA   = 0
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       i_uart_rx,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overflow
);
  localparam logic [31:0] DIV     = calc_div(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] HALF    = DIV / 2;
  localparam int          CW      = $clog2(DIV + 1);
  localparam bit          HAS_PAR = (PARITY != "NONE");
  localparam bit          ODD_PAR = (PARITY == "ODD");

  logic [1:0]    r_sync;
  logic          r_rx_prev;
  logic          w_rx;
  logic          w_fall;
  uart_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par_bit;
  logic          r_frame_err;
  logic          r_parity_err;
  logic          w_tick;
  logic          w_par_ok;
  logic          w_good;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_uart_rx};
      r_rx_prev <= w_rx;
    end
  end

  assign w_rx     = r_sync[1];
  assign w_fall   = r_rx_prev && !w_rx;
  assign w_tick   = (r_cnt == CW'(DIV - 1));
  assign w_par_ok = !HAS_PAR || ((^{r_shift, r_par_bit}) == ODD_PAR);
  assign w_good   = (r_state == ST_STOP) && w_tick && w_rx && w_par_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= ST_START;
        end
        ST_START: begin
          // Line back high at mid start bit means a glitch, not a frame.
          if (r_cnt == CW'(HALF - 1)) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx;
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end else begin
              r_parity_err <= !w_par_ok;
              r_state      <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;

  generate
    if (FIFO_EA == 0) begin : g_reg
      logic       r_tvalid;
      logic [7:0] r_tdata;
      logic       r_overflow;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_tvalid   <= 1'b0;
          r_tdata    <= 8'h00;
          r_overflow <= 1'b0;
        end else begin
          r_overflow <= 1'b0;
          if (w_good) begin
            if (r_tvalid && !o_tready) begin
              r_overflow <= 1'b1;
            end else begin
              r_tvalid <= 1'b1;
              r_tdata  <= r_shift;
            end
          end else if (o_tready) begin
            r_tvalid <= 1'b0;
          end
        end
      end

      assign o_tvalid   = r_tvalid;
      assign o_tdata    = r_tdata;
      assign o_overflow = r_overflow;
    end else begin : g_fifo
      logic       r_push;
      logic [7:0] r_push_data;
      logic       w_empty;
      logic       w_full;
      logic       w_pop;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_push      <= 1'b0;
          r_push_data <= 8'h00;
        end else begin
          r_push      <= w_good;
          r_push_data <= r_shift;
        end
      end

      assign w_pop = !w_empty && o_tready;

      uart_rx_fifo #(
        .EA   (FIFO_EA),
        .FWFT (1'b1)
      ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_data  (o_tdata)
      );

      assign o_tvalid   = !w_empty;
      assign o_overflow = r_push && w_full && !w_pop;
    end
  endgenerate

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three configurations, queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DIV      = 10;
  localparam int HALF     = 5;
  localparam int SYNC_LAT = 3;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [2:0] tv, fe, pe, ov;
  logic [2:0][7:0] td;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("NONE"), .FIFO_EA(0)) dut_n (
    .rstn(rstn), .clk(clk), .i_uart_rx(rx_line[0]), .o_tready(rdy[0]), .o_tvalid(tv[0]),
    .o_tdata(td[0]), .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_overflow(ov[0]));
  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("EVEN"), .FIFO_EA(0)) dut_e (
    .rstn(rstn), .clk(clk), .i_uart_rx(rx_line[1]), .o_tready(rdy[1]), .o_tvalid(tv[1]),
    .o_tdata(td[1]), .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_overflow(ov[1]));
  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("NONE"), .FIFO_EA(2)) dut_f (
    .rstn(rstn), .clk(clk), .i_uart_rx(rx_line[2]), .o_tready(rdy[2]), .o_tvalid(tv[2]),
    .o_tdata(td[2]), .o_frame_err(fe[2]), .o_parity_err(pe[2]), .o_overflow(ov[2]));

  // Per-instance configuration as seen by the model.
  int cap[3]     = '{1, 1, 4};
  bit is_fifo[3] = '{0, 0, 1};
  int nb[3]      = '{8, 9, 8};

  // kind: 0 good byte, 1 frame error, 2 parity error
  typedef struct {int inst; int edge_n; int kind; logic [7:0] data;} arr_t;
  arr_t arr_q[$];

  logic [7:0] mq [3][16];
  int mhead[3], mcnt[3];
  bit saved_pop[3], pend_v[3], pend_ovf[3];
  logic [7:0] pend_d[3];

  int ecount = 0, n_tests = 0, n_fail = 0;
  int xfer_cnt[3], fe_cnt[3], pe_cnt[3], ov_cnt[3], last_rise[3];
  logic [7:0] last_x[3];
  bit prev_tv[3];
  int rmode[3] = '{1, 1, 0};

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %0h, expected %0h", name, inst, ecount, act, exp);
    end
  endtask

  function automatic void mpush(input int i, input logic [7:0] d);
    mq[i][(mhead[i] + mcnt[i]) % 16] = d;
    mcnt[i]++;
  endfunction

  always @(posedge clk) ecount <= ecount + 1;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      rdy[i] = (rmode[i] == 2) ? 1'($urandom_range(0, 1)) : (rmode[i] == 1);
  end

  // Model update for the edge just passed, then compare the current window.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit efe, epe, eov, pop_now;
      efe = 0; epe = 0; eov = 0; pop_now = 0;
      if (!rstn) begin
        mcnt[i] = 0; mhead[i] = 0; saved_pop[i] = 0; pend_v[i] = 0; prev_tv[i] = 0;
        chk("reset_tvalid", i, 32'(tv[i]), 0);
        chk("reset_tdata", i, 32'(td[i]), 0);
        chk("reset_pulses", i, 32'({fe[i], pe[i], ov[i]}), 0);
      end else begin
        if (saved_pop[i]) begin
          mhead[i] = (mhead[i] + 1) % 16;
          mcnt[i]--;
        end
        if (pend_v[i]) begin
          if (!pend_ovf[i]) mpush(i, pend_d[i]);
          pend_v[i] = 0;
        end
        for (int j = arr_q.size() - 1; j >= 0; j--) begin
          if (arr_q[j].inst == i && arr_q[j].edge_n == ecount) begin
            if (arr_q[j].kind == 1) efe = 1;
            else if (arr_q[j].kind == 2) epe = 1;
            else if (is_fifo[i]) begin pend_v[i] = 1; pend_d[i] = arr_q[j].data; end
            else if (mcnt[i] >= cap[i]) eov = 1;
            else mpush(i, arr_q[j].data);
            arr_q.delete(j);
          end
        end
        if (pend_v[i]) begin
          pop_now = (mcnt[i] > 0) && rdy[i];
          pend_ovf[i] = (mcnt[i] - int'(pop_now)) >= cap[i];
          eov = pend_ovf[i];
        end
        chk("tvalid", i, 32'(tv[i]), 32'(mcnt[i] > 0));
        if (mcnt[i] > 0) chk("tdata", i, 32'(td[i]), 32'(mq[i][mhead[i]]));
        chk("frame_err", i, 32'(fe[i]), 32'(efe));
        chk("parity_err", i, 32'(pe[i]), 32'(epe));
        chk("overflow", i, 32'(ov[i]), 32'(eov));
        saved_pop[i] = (mcnt[i] > 0) && rdy[i];
        if (tv[i] && rdy[i]) begin xfer_cnt[i]++; last_x[i] = td[i]; end
        fe_cnt[i] += int'(fe[i]);
        pe_cnt[i] += int'(pe[i]);
        ov_cnt[i] += int'(ov[i]);
        if (tv[i] && !prev_tv[i]) last_rise[i] = ecount;
        prev_tv[i] = tv[i];
      end
    end
    if (!rstn) arr_q.delete();
  end

  // pmode: 0 no parity bit, 1 correct even parity, 2 wrong parity. abort_bits>0 stops after that many data bits.
  task automatic send(input int i, input logic [7:0] d, input int pmode, input bit stop_bad,
                      input int abort_bits, output int s_edge);
    arr_t a;
    int n;
    logic b_val;
    @(posedge clk); #1;
    s_edge = ecount;
    n = nb[i] + 2;
    a.inst = i; a.data = d;
    a.edge_n = s_edge + SYNC_LAT + HALF + DIV * (nb[i] + 1);
    a.kind = stop_bad ? 1 : ((pmode == 2) ? 2 : 0);
    arr_q.push_back(a);
    for (int b = 0; b < n; b++) begin
      if (abort_bits > 0 && b == abort_bits + 1) return;
      if (b == 0) b_val = 1'b0;
      else if (b <= 8) b_val = d[b-1];
      else if (b == 9 && nb[i] == 9) b_val = (pmode == 1) ? ^d : ~^d;
      else b_val = !stop_bad;
      rx_line[i] = b_val;
      repeat (DIV) @(posedge clk);
      #1;
    end
    if (stop_bad) begin
      repeat (20) @(posedge clk);
      #1;
      rx_line[i] = 1'b1;
      repeat (2 * DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic glitch(input int i, input int len);
    @(posedge clk); #1;
    rx_line[i] = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    rx_line[i] = 1'b1;
    repeat (3 * DIV) @(posedge clk);
  endtask

  task automatic rand_run(input int i, input int nframes);
    int s;
    logic [7:0] d;
    bit sb;
    int pm;
    rmode[i] = 2;
    for (int k = 0; k < nframes; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) == 0);
      pm = (nb[i] == 9) ? (($urandom_range(0, 4) == 0) ? 2 : 1) : 0;
      if ($urandom_range(0, 9) == 0) glitch(i, $urandom_range(1, 3));
      send(i, d, pm, sb, 0, s);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    rmode[i] = 1;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s1, x, f, p, o;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);

    // 0xA5, no parity, always ready
    x = xfer_cnt[0]; f = fe_cnt[0]; p = pe_cnt[0]; o = ov_cnt[0];
    send(0, 8'hA5, 0, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("a5_count", 0, 32'(xfer_cnt[0] - x), 1);
    chk("a5_data", 0, 32'(last_x[0]), 32'h A5);
    chk("a5_latency", 0, 32'(last_rise[0] - s), 98);
    chk("a5_errors", 0, 32'((fe_cnt[0] - f) + (pe_cnt[0] - p) + (ov_cnt[0] - o)), 0);

    // short low glitch, then 0x3C
    x = xfer_cnt[0]; f = fe_cnt[0];
    glitch(0, 3);
    chk("glitch_no_byte", 0, 32'(xfer_cnt[0] - x), 0);
    send(0, 8'h3C, 0, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("glitch_then_3c", 0, 32'(last_x[0]), 32'h3C);
    chk("glitch_no_err", 0, 32'(fe_cnt[0] - f), 0);

    // bad stop bit with a held-low line
    x = xfer_cnt[0]; f = fe_cnt[0];
    send(0, 8'h00, 0, 1, 0, s);
    chk("ferr_count", 0, 32'(fe_cnt[0] - f), 1);
    chk("ferr_no_byte", 0, 32'(xfer_cnt[0] - x), 0);
    send(0, 8'h3C, 0, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("after_ferr_3c", 0, 32'(last_x[0]), 32'h3C);

    // even parity: 0x07 with bit 0 is wrong, with bit 1 is right
    x = xfer_cnt[1]; p = pe_cnt[1];
    send(1, 8'h07, 2, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("perr_count", 1, 32'(pe_cnt[1] - p), 1);
    chk("perr_no_byte", 1, 32'(xfer_cnt[1] - x), 0);
    send(1, 8'h07, 1, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("par_ok_data", 1, 32'(last_x[1]), 32'h07);
    chk("par_ok_latency", 1, 32'(last_rise[1] - s), 108);

    // FIFO depth 4 with downstream stalled
    x = xfer_cnt[2]; o = ov_cnt[2];
    s1 = 0;
    for (int k = 1; k <= 5; k++) begin
      send(2, 8'(k), 0, 0, 0, s);
      if (k == 1) s1 = s;
    end
    repeat (5) @(posedge clk); #1;
    chk("fifo_overflow", 2, 32'(ov_cnt[2] - o), 1);
    chk("fifo_latency", 2, 32'(last_rise[2] - s1), 99);
    chk("fifo_stalled", 2, 32'(xfer_cnt[2] - x), 0);
    rmode[2] = 1;
    repeat (20) @(posedge clk); #1;
    chk("fifo_drained", 2, 32'(xfer_cnt[2] - x), 4);
    chk("fifo_last", 2, 32'(last_x[2]), 32'h04);
    chk("fifo_empty", 2, 32'(tv[2]), 0);

    // reset in the middle of 0xFF data bits
    x = xfer_cnt[0];
    send(0, 8'hFF, 0, 0, 5, s);
    rx_line[0] = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    send(0, 8'h12, 0, 0, 0, s);
    repeat (5) @(posedge clk); #1;
    chk("reset_frame_count", 0, 32'(xfer_cnt[0] - x), 1);
    chk("reset_frame_data", 0, 32'(last_x[0]), 32'h12);

    // randomized traffic on all three receivers at once
    fork
      rand_run(0, 30);
      rand_run(1, 30);
      rand_run(2, 30);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
